// File: rtl/sample_frame_buffer_if.sv
// Sample stream bundle between the music player, the frame buffer and the codec.
// The master drives samples and frame strobes; the slave returns readiness and output samples.
interface sample_frame_buffer_if;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic        new_frame;
  logic [15:0] sample_out;

  modport master (
    output sample_in,
    output sample_valid,
    output new_frame,
    input  sample_ready,
    input  sample_out
  );

  modport slave (
    input  sample_in,
    input  sample_valid,
    input  new_frame,
    output sample_ready,
    output sample_out
  );
endinterface

// File: rtl/sample_frame_buffer.sv
// Audio sample FIFO between the player and the codec.
// Primes to half-full before playback, then applies volume and mute on every frame.
module sample_frame_buffer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  sample_frame_buffer_if.slave  bus,
  input  logic [2:0]            volume,
  input  logic                  mute,
  output logic [AW:0]           level,
  output logic [7:0]            underflow_count,
  output logic                  overflow
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] HALF = (AW+1)'(DEPTH / 2);

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [1:0]  rst_sync;
  logic        rst_n;

  logic [15:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic        full;
  logic        wr_en;
  logic        rd_en;
  logic        uflow;
  logic signed [15:0] head;
  logic signed [15:0] scaled;
  logic [15:0] out_q;
  logic [15:0] out_nxt;

  // Assertion reaches the core immediately; release waits two clock edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  assign full             = (level == FULL);
  assign bus.sample_ready = !full;
  assign bus.sample_out   = out_q;

  assign wr_en = bus.sample_valid && !full;
  assign rd_en = bus.new_frame && (state == RUN) && (level != '0);
  assign uflow = bus.new_frame && (state == RUN) && (level == '0);

  assign head   = mem[rd_ptr];
  assign scaled = head >>> volume;

  always_comb begin
    state_nxt = state;
    unique case (state)
      PRIME: if (level >= HALF) state_nxt = RUN;
      RUN:   if (uflow) state_nxt = PRIME;
      default: state_nxt = PRIME;
    endcase
  end

  // Priming, underflow and mute all present silence on the frame.
  always_comb begin
    out_nxt = out_q;
    if (bus.new_frame) begin
      if (rd_en && !mute) begin
        out_nxt = scaled;
      end else begin
        out_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= bus.sample_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= PRIME;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      level           <= '0;
      out_q           <= '0;
      underflow_count <= '0;
      overflow        <= 1'b0;
    end else begin
      state <= state_nxt;
      out_q <= out_nxt;
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (bus.sample_valid && full) begin
        overflow <= 1'b1;
      end
      if (uflow && (underflow_count != 8'hFF)) begin
        underflow_count <= underflow_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sample_frame_buffer.sv
// Scoreboard bench for sample_frame_buffer.
// Frame strobes queue the expected output; a monitor compares it one cycle later.
module tb_sample_frame_buffer;

  logic        clk;
  logic        reset;
  logic [2:0]  volume;
  logic        mute;
  logic [3:0]  level;
  logic [7:0]  underflow_count;
  logic        overflow;

  int n_chk;
  int n_fail;
  logic [15:0] exp_q [$];

  sample_frame_buffer_if bus ();

  sample_frame_buffer #(
    .DEPTH (8),
    .AW    (3)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus),
    .volume          (volume),
    .mute            (mute),
    .level           (level),
    .underflow_count (underflow_count),
    .overflow        (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a frame strobe seen at a rising edge is checked at the next falling edge.
  initial begin
    logic [15:0] e;
    forever begin
      @(posedge clk);
      if (bus.new_frame) begin
        @(negedge clk);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sample_out: got %h with no expected entry", bus.sample_out);
        end else begin
          e = exp_q.pop_front();
          chk("sample_out", {16'h0, bus.sample_out}, {16'h0, e});
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [15:0] v);
    bus.sample_in    = v;
    bus.sample_valid = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
  endtask

  task automatic frame(input logic [15:0] e);
    exp_q.push_back(e);
    bus.new_frame = 1'b1;
    @(negedge clk);
    bus.new_frame = 1'b0;
  endtask

  task automatic wr_frame(input logic [15:0] v, input logic [15:0] e);
    exp_q.push_back(e);
    bus.sample_in    = v;
    bus.sample_valid = 1'b1;
    bus.new_frame    = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    bus.new_frame    = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(3);
  endtask

  initial begin
    n_chk            = 0;
    n_fail           = 0;
    reset            = 1'b0;
    volume           = 3'd0;
    mute             = 1'b0;
    bus.sample_in    = '0;
    bus.sample_valid = 1'b0;
    bus.new_frame    = 1'b0;
    idle(3);
    chk("rst_level", {28'h0, level}, 32'd0);
    chk("rst_sample_out", {16'h0, bus.sample_out}, 32'd0);
    chk("rst_underflow", {24'h0, underflow_count}, 32'd0);
    chk("rst_overflow", {31'h0, overflow}, 32'd0);
    chk("rst_ready", {31'h0, bus.sample_ready}, 32'd1);
    reset = 1'b1;
    idle(3);

    // Prime and play four samples.
    wr(16'h1000); wr(16'h2000); wr(16'h3000); wr(16'h4000);
    chk("prime_level4", {28'h0, level}, 32'd4);
    idle(2);
    frame(16'h1000); frame(16'h2000); frame(16'h3000); frame(16'h4000);
    chk("prime_level0", {28'h0, level}, 32'd0);

    // Below half-full the buffer stays primed.
    do_reset();
    wr(16'h0111); wr(16'h0222); wr(16'h0333);
    idle(2);
    frame(16'h0000);
    chk("hold_level3", {28'h0, level}, 32'd3);
    wr(16'h0444);
    idle(2);
    frame(16'h0111); frame(16'h0222); frame(16'h0333); frame(16'h0444);

    // Volume shifts and mute.
    wr(16'h8000); wr(16'h7FFF); wr(16'h0100); wr(16'h0200);
    idle(2);
    volume = 3'd7; frame(16'hFF00);
    volume = 3'd3; frame(16'h0FFF);
    volume = 3'd1; frame(16'h0080);
    volume = 3'd0; mute = 1'b1; frame(16'h0000);
    mute = 1'b0;
    chk("mute_pop_level", {28'h0, level}, 32'd0);

    // Underflow and saturation.
    frame(16'h0000);
    chk("underflow_1", {24'h0, underflow_count}, 32'd1);
    frame(16'h0000);
    chk("prime_no_uflow", {24'h0, underflow_count}, 32'd1);
    for (int i = 0; i < 300; i++) begin
      for (int j = 0; j < 4; j++) wr(16'(i * 4 + j));
      idle(2);
      for (int j = 0; j < 4; j++) frame(16'(i * 4 + j));
      frame(16'h0000);
    end
    chk("underflow_sat", {24'h0, underflow_count}, 32'd255);

    // Write coincident with an underflow frame is stored, not bypassed.
    wr(16'h0001); wr(16'h0002); wr(16'h0003); wr(16'h0004);
    idle(2);
    frame(16'h0001); frame(16'h0002); frame(16'h0003); frame(16'h0004);
    wr_frame(16'h5555, 16'h0000);
    chk("uflow_wr_level", {28'h0, level}, 32'd1);

    // Overflow, full write+pop, and write+pop at partial fill.
    do_reset();
    chk("ovf_cleared", {31'h0, overflow}, 32'd0);
    for (int k = 1; k <= 9; k++) wr(16'(k * 16'h0011));
    chk("ovf_level", {28'h0, level}, 32'd8);
    chk("ovf_ready", {31'h0, bus.sample_ready}, 32'd0);
    chk("ovf_flag", {31'h0, overflow}, 32'd1);
    idle(2);
    wr_frame(16'h9999, 16'h0011);
    chk("full_wr_pop_level", {28'h0, level}, 32'd7);
    for (int k = 2; k <= 5; k++) frame(16'(k * 16'h0011));
    chk("partial_level", {28'h0, level}, 32'd3);
    wr_frame(16'hAAAA, 16'h0066);
    chk("wr_pop_level", {28'h0, level}, 32'd3);
    frame(16'h0077); frame(16'h0088); frame(16'hAAAA);
    chk("drain_level", {28'h0, level}, 32'd0);
    chk("ovf_sticky", {31'h0, overflow}, 32'd1);

    // Reset in the middle of playback.
    frame(16'h0000);
    chk("pre_rst_uflow", {24'h0, underflow_count}, 32'd1);
    for (int k = 1; k <= 6; k++) wr(16'(16'h0100 + k));
    idle(2);
    frame(16'h0101);
    chk("pre_rst_level", {28'h0, level}, 32'd5);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_level", {28'h0, level}, 32'd0);
    chk("mid_rst_out", {16'h0, bus.sample_out}, 32'd0);
    chk("mid_rst_uflow", {24'h0, underflow_count}, 32'd0);
    chk("mid_rst_ovf", {31'h0, overflow}, 32'd0);
    reset = 1'b1;
    idle(3);
    wr(16'h0AAA); wr(16'h0BBB); wr(16'h0CCC);
    idle(2);
    frame(16'h0000);
    chk("post_rst_prime", {28'h0, level}, 32'd3);

    idle(2);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
